// File: rtl/ping_capture.sv
// Hydrophone ping capture: a circular pre-trigger history that freezes a
// DEPTH-sample window around the first over-threshold sample, then reads it out oldest first.
module ping_capture #(
    parameter int WIDTH    = 10,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             Data_Ready,
    input  logic [WIDTH-1:0] SPI_Data_out,
    input  logic             arm,
    input  logic [WIDTH-2:0] threshold,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_last,
    output logic             armed,
    output logic             capture_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(PRE_TRIG + 1);

    localparam logic [WIDTH-1:0] MID       = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-2:0] MAG_MAX   = '1;
    localparam logic [AW-1:0]    PRE_OFF   = AW'(PRE_TRIG);
    localparam logic [AW-1:0]    POST_INIT = AW'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW-1:0]    LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [PW-1:0]    PRE_FULL  = PW'(PRE_TRIG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state, state_n;

    // ------------------------------------------------------------------
    // Data_Ready crossing and rising-edge strobe
    // ------------------------------------------------------------------
    logic sync1, sync2, ready_q;
    logic sample_stb;

    // Preset to 1 so a Data_Ready already high at reset release is not seen as an edge.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each flop take the previous
            // value of its neighbour, which is what gives a real 2-stage chain.
            sync1   <= Data_Ready;
            sync2   <= sync1;
            ready_q <= sync2;
        end
    end

    assign sample_stb = sync2 & ~ready_q;

    // ------------------------------------------------------------------
    // Sample register; the RAM write happens on the cycle after the strobe
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sample_q;
    logic             wr_pend;
    logic             acquiring;

    assign acquiring = (state == S_ARMED) || (state == S_CAPTURE);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sample_q <= '0;
            wr_pend  <= 1'b0;
        end else begin
            wr_pend <= sample_stb && !arm && acquiring;
            if (sample_stb) begin
                sample_q <= SPI_Data_out;
            end
        end
    end

    // Magnitude about mid-scale, saturated to WIDTH-1 bits (only code 0 overflows).
    logic [WIDTH-1:0] diff;
    logic [WIDTH-2:0] mag;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch can never be inferred.
        diff = '0;
        mag  = '0;
        if (sample_q[WIDTH-1]) begin
            diff = sample_q - MID;
        end else begin
            diff = MID - sample_q;
        end
        if (diff[WIDTH-1]) begin
            mag = MAG_MAX;
        end else begin
            mag = diff[WIDTH-2:0];
        end
    end

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_ptr, start_ptr, rd_ptr, post_cnt, rd_cnt;
    logic [PW-1:0] pre_cnt;

    logic samp_write;
    logic trig_hit;
    logic cap_end;
    logic rd_fire;
    logic last_rd;

    assign samp_write = wr_pend && !arm && acquiring;
    assign trig_hit   = (state == S_ARMED) && (pre_cnt == PRE_FULL) && (mag > threshold);
    assign cap_end    = (state == S_CAPTURE) && (post_cnt == AW'(1));
    assign rd_fire    = (state == S_DONE) && rd_en && !arm;
    assign last_rd    = rd_fire && (rd_cnt == LAST_IDX);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (arm) begin
            state_n = S_ARMED;
        end else begin
            unique case (state)
                S_IDLE:    state_n = S_IDLE;
                S_ARMED:   if (samp_write && trig_hit) state_n = S_CAPTURE;
                S_CAPTURE: if (samp_write && cap_end)  state_n = S_DONE;
                S_DONE:    if (last_rd)                state_n = S_IDLE;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    assign armed        = acquiring;
    assign capture_done = (state == S_DONE);

    // ------------------------------------------------------------------
    // Pointers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr    <= '0;
            start_ptr <= '0;
            rd_ptr    <= '0;
            post_cnt  <= '0;
            rd_cnt    <= '0;
            pre_cnt   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else if (arm) begin
            wr_ptr    <= '0;
            start_ptr <= '0;
            post_cnt  <= '0;
            rd_cnt    <= '0;
            pre_cnt   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            rd_last  <= last_rd;

            if (samp_write) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (state == S_ARMED) begin
                    if (trig_hit) begin
                        // wr_ptr still addresses the trigger slot here.
                        start_ptr <= wr_ptr - PRE_OFF;
                        post_cnt  <= POST_INIT;
                    end else if (pre_cnt != PRE_FULL) begin
                        pre_cnt <= pre_cnt + PW'(1);
                    end
                end else begin
                    post_cnt <= post_cnt - AW'(1);
                    if (cap_end) begin
                        rd_ptr <= start_ptr;
                        rd_cnt <= '0;
                    end
                end
            end

            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
                rd_cnt <= rd_cnt + AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Window RAM: one write port, one registered read port
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ram_q;

    // NOTE: the RAM and its read register carry no reset so the array maps onto
    // block RAM; rd_data is forced to 0 outside rd_valid instead.
    always_ff @(posedge clk) begin
        if (samp_write) begin
            mem[wr_ptr] <= sample_q;
        end
        if (rd_fire) begin
            ram_q <= mem[rd_ptr];
        end
    end

    assign rd_data = rd_valid ? ram_q : '0;

endmodule

// File: tb/tb_ping_capture.sv
// Directed bench for ping_capture: trigger rules, window contents and order,
// wrap-around, arm/reset edge cases; expected windows come from the bench's own sample history.
module tb_ping_capture;

    localparam int WIDTH    = 10;
    localparam int DEPTH    = 256;
    localparam int PRE_TRIG = 64;
    localparam int POST     = DEPTH - PRE_TRIG - 1;

    logic             clk = 1'b0;
    logic             reset_b;
    logic             Data_Ready;
    logic [WIDTH-1:0] SPI_Data_out;
    logic             arm;
    logic [WIDTH-2:0] threshold;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_last;
    logic             armed;
    logic             capture_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] got[DEPTH];
    logic             got_last[DEPTH];

    ping_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .Data_Ready   (Data_Ready),
        .SPI_Data_out (SPI_Data_out),
        .arm          (arm),
        .threshold    (threshold),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_last      (rd_last),
        .armed        (armed),
        .capture_done (capture_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sample frame: Data_Ready high 2 cycles, low 2 cycles (rising edges 4 clk apart).
    task automatic send(input logic [WIDTH-1:0] v);
        SPI_Data_out = v;
        Data_Ready   = 1'b1;
        hist.push_back(v);
        repeat (2) @(negedge clk);
        Data_Ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_fill(input int n, input logic [WIDTH-1:0] v);
        for (int i = 0; i < n; i++) send(v);
    endtask

    task automatic send_count(input int n);
        for (int i = 0; i < n; i++) send(WIDTH'(i));
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        hist.delete();
    endtask

    // Post-trigger samples, checking completion lands exactly on the last one.
    task automatic send_post(input string tag);
        send_count(POST - 1);
        check({tag, " done_early"}, capture_done, 0);
        send(WIDTH'(POST - 1));
        check({tag, " done"}, capture_done, 1);
        check({tag, " armed_off"}, armed, 0);
    endtask

    task automatic read_window(input string tag, input int trig_idx);
        int n;
        int n_last;
        n      = 0;
        n_last = 0;
        rd_en  = 1'b1;
        for (int c = 0; c < DEPTH + 4 && n < DEPTH; c++) begin
            @(negedge clk);
            if (rd_valid) begin
                got[n]      = rd_data;
                got_last[n] = rd_last;
                if (rd_last) n_last++;
                n++;
            end
            if (n == DEPTH) rd_en = 1'b0;
        end
        rd_en = 1'b0;
        check({tag, " read_count"}, n, DEPTH);
        check({tag, " last_count"}, n_last, 1);
        if (n == DEPTH) begin
            check({tag, " last_flag"}, got_last[DEPTH-1], 1);
            for (int i = 0; i < DEPTH; i++) begin
                check($sformatf("%s win[%0d]", tag, i), got[i], hist[trig_idx - PRE_TRIG + i]);
            end
        end
        @(negedge clk);
        check({tag, " done_cleared"}, capture_done, 0);
        check({tag, " idle_armed"}, armed, 0);
        check({tag, " valid_cleared"}, rd_valid, 0);
    endtask

    task automatic rd_idle_probe(input string tag);
        int seen;
        seen  = 0;
        rd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_valid) seen++;
        end
        rd_en = 1'b0;
        check({tag, " no_valid"}, seen, 0);
    endtask

    initial begin
        reset_b      = 1'b0;
        Data_Ready   = 1'b0;
        SPI_Data_out = '0;
        arm          = 1'b0;
        threshold    = 9'd100;
        rd_en        = 1'b0;
        #12;
        check("rst rd_data", rd_data, 0);
        check("rst rd_valid", rd_valid, 0);
        check("rst rd_last", rd_last, 0);
        check("rst armed", armed, 0);
        check("rst done", capture_done, 0);
        @(negedge clk);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        rd_idle_probe("idle_rd");

        // Basic capture: 64 x 512, trigger 700, post ramp 0..190.
        arm_pulse();
        check("t1 armed", armed, 1);
        send_fill(PRE_TRIG, 10'd512);
        send(10'd700);
        check("t1 capturing", armed, 1);
        send_post("t1");
        read_window("t1", PRE_TRIG);
        check("t1 first", got[0], 512);
        check("t1 trig", got[64], 700);
        check("t1 post0", got[65], 0);
        check("t1 last", got[255], 190);

        // Early over-threshold samples must not trigger.
        arm_pulse();
        for (int i = 0; i < PRE_TRIG; i++) send((i == 5 || i == 30) ? 10'd300 : 10'd512);
        check("t2 still_armed", armed, 1);
        check("t2 not_done", capture_done, 0);
        send(10'd800);
        send_post("t2");
        read_window("t2", PRE_TRIG);
        check("t2 trig", got[64], 800);
        check("t2 early5", got[5], 300);

        // Long ramp wraps wr_ptr; threshold at max blocks triggering until lowered.
        threshold = 9'd511;
        arm_pulse();
        for (int i = 0; i < 1000; i++) send(WIDTH'(i % 1024));
        check("t3 no_trig", armed, 1);
        threshold = 9'd100;
        send(10'd700);
        send_post("t3");
        read_window("t3", 1000);
        check("t3 first", got[0], 936);
        check("t3 pre_last", got[63], 999);

        // mag == threshold does not trigger; one more does.
        arm_pulse();
        send_fill(PRE_TRIG, 10'd512);
        send(10'd612);
        send(10'd613);
        send_post("t4a");
        read_window("t4a", PRE_TRIG + 1);
        check("t4a eq", got[63], 612);
        check("t4a trig", got[64], 613);

        // Saturation: sample 0 -> mag 511 > 510; sample 2 -> mag 510 not > 510.
        threshold = 9'd510;
        arm_pulse();
        send_fill(PRE_TRIG, 10'd512);
        send(10'd2);
        send(10'd0);
        send_post("t4b");
        read_window("t4b", PRE_TRIG + 1);
        check("t4b trig", got[64], 0);
        threshold = 9'd100;

        // Reset mid-capture with Data_Ready held high.
        arm_pulse();
        send_fill(PRE_TRIG, 10'd512);
        send(10'd700);
        send_count(20);
        SPI_Data_out = 10'd999;
        Data_Ready   = 1'b1;
        repeat (3) @(negedge clk);
        check("t5 pre_rst_armed", armed, 1);
        #2 reset_b = 1'b0;
        #1;
        check("t5 rst armed", armed, 0);
        check("t5 rst done", capture_done, 0);
        check("t5 rst valid", rd_valid, 0);
        check("t5 rst data", rd_data, 0);
        check("t5 rst last", rd_last, 0);
        @(negedge clk);
        reset_b = 1'b1;
        arm_pulse();
        repeat (4) @(negedge clk);
        Data_Ready = 1'b0;
        repeat (2) @(negedge clk);
        send_fill(PRE_TRIG - 1, 10'd512);
        send(10'd700);
        check("t5 no_spurious", armed, 1);
        send(10'd700);
        send_post("t5");
        read_window("t5", PRE_TRIG);

        // arm during CAPTURE restarts with no trigger carried over.
        arm_pulse();
        send_fill(PRE_TRIG, 10'd512);
        send(10'd700);
        send_count(50);
        arm_pulse();
        check("t6 rearmed", armed, 1);
        for (int i = 0; i < PRE_TRIG; i++) send(WIDTH'(100 + i));
        send(10'd700);
        send_post("t6");

        // arm during readout, coincident with rd_en: arm wins.
        rd_en = 1'b1;
        repeat (10) @(negedge clk);
        check("t6 reading", rd_valid, 1);
        check("t6 rd9", rd_data, 109);
        arm = 1'b1;
        @(negedge clk);
        check("t6 arm_vs_rd", rd_valid, 0);
        check("t6 arm_state", armed, 1);
        check("t6 arm_done", capture_done, 0);
        arm   = 1'b0;
        rd_en = 1'b0;
        hist.delete();
        rd_idle_probe("armed_rd");
        send_fill(PRE_TRIG, 10'd400);
        send(10'd900);
        send_post("t6b");
        read_window("t6b", PRE_TRIG);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ping_capture.md
Name: ping_capture

Overview:
- Downstream consumer of the SPI ADC receiver. Takes each WIDTH-bit hydrophone sample and its Data_Ready strobe, and keeps a rolling pre-trigger history in a circular RAM.
- Detects a ping when the sample magnitude about mid-scale exceeds a programmable threshold. It then freezes a DEPTH-sample window (PRE_TRIG samples before the trigger plus the trigger and post-trigger samples) for sequential readout by the DSP/host side.

Parameters:
- WIDTH, 10: ADC sample width; offset-binary, mid-scale MID = 2^(WIDTH-1).
- DEPTH, 256: capture window length in samples; power of two, >= 4.
- PRE_TRIG, 64: samples retained before the trigger sample; 1 <= PRE_TRIG <= DEPTH-2.

Ports:
- clk  in  1  system clock.
- reset_b  in  1  asynchronous active-low reset.
- Data_Ready  in  1  sample-valid level from the SPI receiver, SPI_clk domain, asynchronous to clk.
- SPI_Data_out  in  WIDTH  sample from the SPI receiver; stable from the Data_Ready rise until the next frame.
- arm  in  1  one-cycle pulse; clears the window and starts (or restarts) acquisition.
- threshold  in  WIDTH-1  magnitude trigger level, quasi-static.
- rd_en  in  1  read request, honoured only in DONE.
- rd_data  out  WIDTH  readout sample.
- rd_valid  out  1  rd_data valid this cycle.
- rd_last  out  1  with rd_valid, marks the final (DEPTH-th) sample.
- armed  out  1  high in ARMED or CAPTURE.
- capture_done  out  1  high in DONE.

Behaviour:
- Reset (async, reset_b=0):
  - State goes to IDLE; all pointers and counters go to 0.
  - rd_data=0; rd_valid, rd_last, armed and capture_done are 0.
  - The two sync flops and the edge-detect flop reset to 1, so a Data_Ready already high at reset release produces no strobe.
  - Reset mid-capture discards the window; RAM contents are don't-care.
- Input sync:
  - Data_Ready passes through a 2-flop synchroniser, then rising-edge detection produces a one-cycle sample_stb.
  - SPI_Data_out is registered on the sample_stb cycle and written to RAM on the next cycle.
  - Input constraints: Data_Ready high >= 2 clk cycles; rising edges >= 4 clk cycles apart.
- Magnitude:
  - mag = SPI_Data_out - MID if SPI_Data_out >= MID, else MID - SPI_Data_out.
  - Saturate mag to 2^(WIDTH-1)-1.
  - Trigger condition is strict: mag > threshold.
- FSM transitions:
  - IDLE: samples ignored. arm -> ARMED; clear wr_ptr and pre_cnt. A sample_stb in the same cycle as arm is ignored.
  - ARMED:
    - Each sample is written to mem[wr_ptr]; wr_ptr increments modulo DEPTH (wraps freely).
    - pre_cnt increments, saturating at PRE_TRIG.
    - A trigger is accepted only when pre_cnt == PRE_TRIG at the strobe; earlier over-threshold samples are stored but do not trigger.
    - On trigger: store the sample; start_ptr = (wr_ptr - PRE_TRIG) mod DEPTH; post_cnt = DEPTH-PRE_TRIG-1; go to CAPTURE.
  - CAPTURE:
    - Each sample is written and post_cnt decrements.
    - Further over-threshold samples have no effect.
    - When the sample that takes post_cnt to 0 is written -> DONE; rd_ptr = start_ptr, rd_cnt = 0.
  - DONE:
    - Samples ignored; RAM is frozen.
    - rd_en -> next cycle rd_valid=1, rd_data=mem[rd_ptr]; rd_ptr and rd_cnt increment.
    - rd_en may be held high for back-to-back reads, one per cycle.
    - On the DEPTH-th read, rd_last=1 with rd_valid; the next cycle state -> IDLE and capture_done=0.
- Arm and read edge cases:
  - arm in ARMED, CAPTURE or DONE: restart at ARMED with cleared counters and no trigger carried over. Any unread data is lost.
  - arm in the same cycle as rd_en in DONE: arm wins; no read is issued.
  - rd_en outside DONE is ignored; rd_valid stays 0.
- Read order: window samples come out oldest first. Sample index PRE_TRIG (0-based) is the trigger sample.
- Memory: a single DEPTH x WIDTH RAM with one write port and one synchronous read port, inferable as block RAM.

Test Plan:
- Defaults; arm; feed 64 samples of 512, then 700 (mag 188 > threshold 100), then 191 samples counting 0..190 -> capture_done=1. 256 reads: first 64 = 512, index 64 = 700, index 65 = 0, last = 190 with rd_last=1; then capture_done=0.
- threshold=100; arm; samples 5 and 30 at value 300 (mag 212) inside the first 63 samples, then the 64th sample = 512 -> no trigger, armed stays 1. Next sample 800 -> trigger; read index 64 = 800.
- Feed 1000 ramp samples (value i mod 1024) before the trigger -> wr_ptr has wrapped; the window's first 64 samples are the 64 ramp values immediately preceding the trigger, in order.
- Boundary: mag == threshold (sample 612, threshold 100) -> no trigger; 613 -> trigger. Sample 0 gives mag 511 (saturated); threshold 510 -> trigger.
- Reset asserted mid-CAPTURE and while Data_Ready is held high -> all outputs 0 immediately; after release, no strobe until Data_Ready falls and rises again; re-arm and capture complete correctly.
- arm during CAPTURE and again during readout -> window restarts. rd_en issued in IDLE/ARMED -> rd_valid never asserts. Data_Ready edges 4 clk apart are all captured.
